// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - three-requester arbiter and pipeline sequencer for a 32x32 register file
module regfile_access_ctrl #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int PROTECT_R0   = 1,
   parameter int WB_MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_valid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [DATA_W-1:0] rf_in,
   output logic [ADDR_W-1:0] rf_addr_a,
   output logic [ADDR_W-1:0] rf_addr_b,
   output logic              rf_rw,
   output logic              rf_sel,
   input  logic [DATA_W-1:0] rf_out_a,
   input  logic [DATA_W-1:0] rf_out_b
);

   localparam int CNT_W = $clog2(WB_MAX_BURST + 1);

   typedef enum logic [1:0] {TAG_NONE, TAG_RD, TAG_DBG_RD, TAG_DBG_WR} tag_t;

   logic              rr_dbg;      // 0: rd wins a rd/dbg tie, 1: dbg wins
   logic [CNT_W-1:0]  burst_cnt;
   tag_t              tag_s1, tag_s2;
   logic              pending, wb_mask, wr_gnt, wr_blocked;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign pending = rd_req | dbg_req;
   assign wb_mask = pending && (burst_cnt == CNT_W'(WB_MAX_BURST));

   // Grants are gated by rst_n so nothing is accepted while reset is asserted
   always_comb begin
      wb_gnt  = rst_n & wb_req & ~wb_mask;
      rd_gnt  = rst_n & ~wb_gnt & rd_req  & (~dbg_req | ~rr_dbg);
      dbg_gnt = rst_n & ~wb_gnt & dbg_req & (~rd_req  |  rr_dbg);
   end

   assign wr_gnt     = wb_gnt | (dbg_gnt & dbg_we);
   assign wr_addr    = wb_gnt ? wb_addr : dbg_addr;
   assign wr_data    = wb_gnt ? wb_data : dbg_wdata;
   assign wr_blocked = (PROTECT_R0 != 0) && (wr_addr == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_dbg    <= 1'b0;
         burst_cnt <= '0;
      end else begin
         if (rd_gnt)
            rr_dbg <= 1'b1;
         else if (dbg_gnt)
            rr_dbg <= 1'b0;
         if (!pending || rd_gnt || dbg_gnt)
            burst_cnt <= '0;
         else if (wb_gnt)
            burst_cnt <= burst_cnt + CNT_W'(1);
      end
   end

   // Register-file pins, valid during the cycle after the grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_sel    <= 1'b1;
         rf_rw     <= 1'b1;
         rf_in     <= '0;
         rf_addr_a <= '0;
         rf_addr_b <= '0;
      end else if (wr_gnt) begin
         rf_sel    <= wr_blocked;
         rf_rw     <= 1'b0;
         rf_in     <= wr_data;
         rf_addr_a <= wr_addr;
         rf_addr_b <= '0;
      end else if (rd_gnt) begin
         rf_sel    <= 1'b0;
         rf_rw     <= 1'b1;
         rf_addr_a <= rd_addr_a;
         rf_addr_b <= rd_addr_b;
      end else if (dbg_gnt) begin
         rf_sel    <= 1'b0;
         rf_rw     <= 1'b1;
         rf_addr_a <= dbg_addr;
         rf_addr_b <= '0;
      end else begin
         rf_sel    <= 1'b1;
         rf_rw     <= 1'b1;
      end
   end

   // Requester tags travel alongside the access so responses come back in grant order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_s1    <= TAG_NONE;
         tag_s2    <= TAG_NONE;
         rd_valid  <= 1'b0;
         dbg_valid <= 1'b0;
         rd_data_a <= '0;
         rd_data_b <= '0;
         dbg_rdata <= '0;
      end else begin
         if (rd_gnt)
            tag_s1 <= TAG_RD;
         else if (dbg_gnt)
            tag_s1 <= dbg_we ? TAG_DBG_WR : TAG_DBG_RD;
         else
            tag_s1 <= TAG_NONE;
         tag_s2    <= tag_s1;
         rd_valid  <= (tag_s2 == TAG_RD);
         dbg_valid <= (tag_s2 == TAG_DBG_RD) || (tag_s2 == TAG_DBG_WR);
         if (tag_s2 == TAG_RD) begin
            rd_data_a <= rf_out_a;
            rd_data_b <= rf_out_b;
         end
         if (tag_s2 == TAG_DBG_RD)
            dbg_rdata <= rf_out_a;
         else if (tag_s2 == TAG_DBG_WR)
            dbg_rdata <= '0;
      end
   end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - cycle-table bench for regfile_access_ctrl with a register file model
module tb_regfile_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_req = 1'b0, rd_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
   logic [4:0]  wb_addr = '0, rd_addr_a = '0, rd_addr_b = '0, dbg_addr = '0;
   logic [31:0] wb_data = '0, dbg_wdata = '0;
   logic        wb_gnt, rd_gnt, rd_valid, dbg_gnt, dbg_valid, rf_rw, rf_sel;
   logic [31:0] rd_data_a, rd_data_b, dbg_rdata, rf_in;
   logic [4:0]  rf_addr_a, rf_addr_b;
   logic [31:0] rf_out_a = '0, rf_out_b = '0;
   logic [31:0] mem [32];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
      .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata),
      .rf_in(rf_in), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_rw(rf_rw),
      .rf_sel(rf_sel), .rf_out_a(rf_out_a), .rf_out_b(rf_out_b)
   );

   // Register file: one write or one dual read per clock when selected
   always @(posedge clk) begin
      if (!rf_sel) begin
         if (!rf_rw)
            mem[rf_addr_a] <= rf_in;
         else begin
            rf_out_a <= mem[rf_addr_a];
            rf_out_b <= mem[rf_addr_b];
         end
      end
   end

   typedef struct {
      logic wb; logic [4:0] wa; logic [31:0] wd;
      logic rd; logic [4:0] ra; logic [4:0] rb;
      logic dbg; logic we; logic [4:0] da; logic [31:0] dw;
      logic [2:0] gnt; logic sel;
      logic rv; logic [31:0] ea; logic [31:0] eb;
      logic dv; logic [31:0] ed;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t vr(logic wb, logic [4:0] wa, logic [31:0] wd,
                               logic rd, logic [4:0] ra, logic [4:0] rb,
                               logic dbg, logic we, logic [4:0] da, logic [31:0] dw,
                               logic [2:0] gnt, logic sel,
                               logic rv, logic [31:0] ea, logic [31:0] eb,
                               logic dv, logic [31:0] ed);
      vec_t v;
      v.wb = wb; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra; v.rb = rb;
      v.dbg = dbg; v.we = we; v.da = da; v.dw = dw; v.gnt = gnt; v.sel = sel;
      v.rv = rv; v.ea = ea; v.eb = eb; v.dv = dv; v.ed = ed;
      return v;
   endfunction

   function automatic vec_t vi(logic sel, logic rv, logic [31:0] ea, logic [31:0] eb,
                               logic dv, logic [31:0] ed);
      return vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, sel, rv, ea, eb, dv, ed);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_req = 0; rd_req = 0; dbg_req = 0; dbg_we = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'(0);
      for (int i = 1; i <= 4; i++) mem[i] = 32'(i);

      // Concurrent wb/rd/dbg: wb first, then rd, then dbg
      vecs.push_back(vr(1, 7, 32'hA5A5A5A5, 1, 1, 2, 1, 0, 3, 0, 3'b100, 1, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0,            1, 1, 2, 1, 0, 3, 0, 3'b010, 0, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0,            0, 0, 0, 1, 0, 3, 0, 3'b001, 0, 0, 0, 0, 0, 0));
      vecs.push_back(vi(0, 0, 0, 0, 0, 0));
      vecs.push_back(vi(1, 1, 32'd1, 32'd2, 0, 0));
      vecs.push_back(vi(1, 0, 0, 0, 1, 32'd3));
      // Write r5 then read it the next cycle
      vecs.push_back(vr(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0,            1, 5, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
      vecs.push_back(vi(0, 0, 0, 0, 0, 0));
      vecs.push_back(vi(1, 0, 0, 0, 0, 0));
      vecs.push_back(vi(1, 1, 32'h12345678, 32'h0, 0, 0));
      // Debug read r4, protected write r0, read r0
      vecs.push_back(vr(0, 0, 0, 0, 0, 0, 1, 0, 4, 0,            3'b001, 1, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 3'b001, 0, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,            3'b001, 1, 0, 0, 0, 0, 0));
      vecs.push_back(vi(0, 0, 0, 0, 1, 32'd4));
      vecs.push_back(vi(1, 0, 0, 0, 1, 32'd0));
      vecs.push_back(vi(1, 0, 0, 0, 1, 32'd0));
      // Back-to-back debug reads r1..r4
      vecs.push_back(vr(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3'b001, 1, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 3'b001, 0, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 3'b001, 0, 0, 0, 0, 0, 0));
      vecs.push_back(vr(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 3'b001, 0, 0, 0, 0, 1, 32'd1));
      vecs.push_back(vi(0, 0, 0, 0, 1, 32'd2));
      vecs.push_back(vi(1, 0, 0, 0, 1, 32'd3));
      vecs.push_back(vi(1, 0, 0, 0, 1, 32'd4));
      vecs.push_back(vi(1, 0, 0, 0, 0, 0));
      // wb burst against a pending rd: 4 wb, 1 rd, 4 wb, 1 rd
      for (int i = 0; i < 10; i++) begin
         logic is_rd;
         is_rd = (i == 4) || (i == 9);
         vecs.push_back(vr(1, 9, 32'h99, 1, 5, 7, 0, 0, 0, 0, is_rd ? 3'b010 : 3'b100,
                           (i == 0), (i == 7), 32'h12345678, 32'hA5A5A5A5, 0, 0));
      end
      vecs.push_back(vi(0, 0, 0, 0, 0, 0));
      vecs.push_back(vi(1, 0, 0, 0, 0, 0));
      vecs.push_back(vi(1, 1, 32'h12345678, 32'hA5A5A5A5, 0, 0));

      // Reset state
      tick();
      tick();
      chk("reset_rf_sel", 32'(rf_sel), 32'd1);
      chk("reset_rf_rw", 32'(rf_rw), 32'd1);
      chk("reset_rf_addr", {22'd0, rf_addr_a, rf_addr_b}, 32'd0);
      chk("reset_rf_in", rf_in, 32'd0);
      chk("reset_valids", {30'd0, rd_valid, dbg_valid}, 32'd0);
      chk("reset_data", rd_data_a | rd_data_b | dbg_rdata, 32'd0);
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         wb_req = vecs[k].wb; wb_addr = vecs[k].wa; wb_data = vecs[k].wd;
         rd_req = vecs[k].rd; rd_addr_a = vecs[k].ra; rd_addr_b = vecs[k].rb;
         dbg_req = vecs[k].dbg; dbg_we = vecs[k].we; dbg_addr = vecs[k].da; dbg_wdata = vecs[k].dw;
         @(negedge clk);
         chk($sformatf("v%0d_gnt", k), {29'd0, wb_gnt, rd_gnt, dbg_gnt}, {29'd0, vecs[k].gnt});
         chk($sformatf("v%0d_rf_sel", k), 32'(rf_sel), 32'(vecs[k].sel));
         chk($sformatf("v%0d_rd_valid", k), 32'(rd_valid), 32'(vecs[k].rv));
         chk($sformatf("v%0d_dbg_valid", k), 32'(dbg_valid), 32'(vecs[k].dv));
         if (vecs[k].rv) begin
            chk($sformatf("v%0d_rd_data_a", k), rd_data_a, vecs[k].ea);
            chk($sformatf("v%0d_rd_data_b", k), rd_data_b, vecs[k].eb);
         end
         if (vecs[k].dv)
            chk($sformatf("v%0d_dbg_rdata", k), dbg_rdata, vecs[k].ed);
         tick();
      end
      idle_inputs();

      // Reset one cycle after an rd grant: in-flight read dropped
      rd_req = 1; rd_addr_a = 5; rd_addr_b = 7;
      @(negedge clk);
      chk("rst_seq_rd_gnt", 32'(rd_gnt), 32'd1);
      tick();
      rd_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_rf_sel", 32'(rf_sel), 32'd1);
      chk("rst_async_rf_rw", 32'(rf_rw), 32'd1);
      chk("rst_async_rf_addr", {27'd0, rf_addr_a}, 32'd0);
      chk("rst_async_gnt", {29'd0, wb_gnt, rd_gnt, dbg_gnt}, 32'd0);
      chk("rst_async_data", rd_data_a | dbg_rdata, 32'd0);
      tick();
      tick();
      dbg_req = 0;
      rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen += int'(rd_valid) + int'(dbg_valid);
            tick();
         end
         chk("rst_dropped_pulses", 32'(seen), 32'd0);
      end

      // After release the rr pointer must favour rd again
      rd_req = 1; dbg_req = 1; dbg_addr = 2;
      @(negedge clk);
      chk("post_rst_gnt_rd", {29'd0, wb_gnt, rd_gnt, dbg_gnt}, 32'b010);
      tick();
      rd_req = 0;
      @(negedge clk);
      chk("post_rst_gnt_dbg", {29'd0, wb_gnt, rd_gnt, dbg_gnt}, 32'b001);
      tick();
      dbg_req = 0;
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_c%0d_valids", i), {30'd0, rd_valid, dbg_valid},
             (i == 3) ? 32'b10 : (i == 4) ? 32'b01 : 32'b00);
         if (i == 3) begin
            chk("post_rst_rd_a", rd_data_a, 32'h12345678);
            chk("post_rst_rd_b", rd_data_b, 32'hA5A5A5A5);
         end
         if (i == 4)
            chk("post_rst_dbg", dbg_rdata, 32'd2);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Arbitration and sequencing front-end for the 32x32 single-write-port register file, which performs either one write or one dual read per clock.
- Shares the file between three requesters: pipeline writeback (wb), operand read (rd, two addresses) and the debug port (dbg, read or write).
- Drives the register file's in/addr/rw/sel pins from registers and returns read data with a fixed latency.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- PROTECT_R0, 1, when 1 writes to address 0 are acknowledged but not issued.
- WB_MAX_BURST, 4, consecutive wb grants allowed while rd or dbg is pending.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_req  in  1  writeback request, held until granted.
- wb_addr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- wb_gnt  out  1  combinational grant, accepted at this edge.
- rd_req  in  1  operand read request.
- rd_addr_a  in  ADDR_W  operand A address.
- rd_addr_b  in  ADDR_W  operand B address.
- rd_gnt  out  1  combinational grant.
- rd_valid  out  1  one-cycle pulse, operand data valid.
- rd_data_a  out  DATA_W  operand A.
- rd_data_b  out  DATA_W  operand B.
- dbg_req  in  1  debug request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write value.
- dbg_gnt  out  1  combinational grant.
- dbg_valid  out  1  one-cycle completion pulse (reads and writes).
- dbg_rdata  out  DATA_W  debug read data, 0 for writes.
- rf_in  out  DATA_W  to register file in_reg.
- rf_addr_a  out  ADDR_W  to addr_a (write address or read A).
- rf_addr_b  out  ADDR_W  to addr_b.
- rf_rw  out  1  1 = read, 0 = write.
- rf_sel  out  1  active-low chip select.
- rf_out_a  in  DATA_W  from register file out_a.
- rf_out_b  in  DATA_W  from register file out_b.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - rf_sel=1, rf_rw=1, rf_in/rf_addr_a/rf_addr_b=0.
  - All gnt, valid and data outputs 0.
  - Pipeline tags cleared; burst counter 0; round-robin pointer = rd.
  - In-flight operations are dropped with no response.
- Arbitration: at most one grant per cycle; a request is accepted when req & gnt at a rising edge.
  - wb has highest priority.
  - rd and dbg alternate round-robin; the pointer advances only when one of them is granted.
- Burst limit:
  - The burst counter increments on each wb grant while rd or dbg is pending.
  - It clears on any rd/dbg grant, or when neither rd nor dbg is pending.
  - When counter == WB_MAX_BURST and rd or dbg is pending, wb is masked for one cycle.
- Pipeline (grant in cycle C):
  - C: gnt high; the rf_* registers load at the end of C.
  - C+1: rf_sel=0 and rf_rw/addrs/rf_in are valid; the register file executes at the end of C+1.
  - C+2: the controller samples rf_out_a/b into its data registers at the end of C+2.
  - C+3: rd_valid or dbg_valid high for exactly one cycle with the registered data.
  - Read latency = 3 cycles; throughput = one operation per cycle, back-to-back across requesters.
- rf_sel returns to 1 in any cycle following a cycle with no grant.
- Ordering:
  - A write granted in C is visible to a read granted in C+1 or later; no forwarding is needed.
  - Responses return in grant order, tagged internally by requester (2-bit tag, 2-stage shift).
- Write encoding: rf_rw=0, rf_addr_a=target, rf_in=data, rf_addr_b=0.
- R0 protection: when PROTECT_R0=1 and the write address is 0:
  - The request is still granted.
  - rf_sel stays 1 for that slot.
  - dbg_valid still pulses at C+3; wb gets no response.
- Idle: with no requests, gnts are 0, rf_sel=1 and no valid pulses occur.
- rd_data_*/dbg_rdata hold their last value between pulses; dbg_rdata is 0 on write completion.

Test Plan:
- Reset then wb write r5=0x1234_5678 in C0, rd read A=5,B=0 in C1 -> rd_valid in C4, rd_data_a=0x12345678, rd_data_b=0.
- wb, rd and dbg all requesting in the same cycle -> wb_gnt first; then rd and dbg alternate; grant order wb,rd,dbg with rd/dbg pointer updated.
- wb_req held high for 10 cycles while rd_req is pending -> 4 wb grants, 1 rd grant, 4 wb grants, and so on; rd_valid 3 cycles after its grant.
- dbg write r0=0xFFFF_FFFF with PROTECT_R0=1, then dbg read r0 -> rf_sel stays 1 for the write slot; dbg_valid pulses twice; dbg_rdata=0 on the read.
- Assert rst_n=0 one cycle after an rd grant -> no rd_valid pulse; outputs 0 and rf_sel=1 immediately; normal operation after release.
- Back-to-back dbg reads of r1..r4 preloaded with 1..4 -> four consecutive dbg_valid cycles with data 1,2,3,4.
